pc_unit_param: RTL and testbench
================================

Name: pc_unit_param

Overview:
Parametrised program-counter unit for the multi-cycle MIPS datapath, and the successor to the fixed 32-bit PC.
- Owns the PC register, its write-enable / conditional-branch qualification and the 4-way next-PC select.
- Adds exception redirect with EPC capture, a post-trap hold window and an update counter.
- Sits between the control FSM (pc_write, pc_write_cond, pc_src) and the ALU/jump datapath; drives the instruction-memory address.

Parameters:
WIDTH, 32, PC/address width (>=8)
RESET_VEC, 0, PC value after reset
EXC_VEC, 'h180, exception handler address (truncated to WIDTH)
ALIGN_BITS, 2, low address bits that must be zero for a legal target
HOLD_CYCLES, 1, cycles PC writes are ignored after an exception redirect (0 = none)
CNT_WIDTH, 32, width of the PC-update counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
pc_write  in  1  unconditional PC write enable
pc_write_cond  in  1  branch write enable, qualified by zero/branch_ne
zero  in  1  ALU zero flag
branch_ne  in  1  1 = take branch when zero==0 (bne), 0 = when zero==1 (beq)
pc_src  in  2  0=alu_result, 1=alu_out, 2=jump_address, 3=EXC_VEC
alu_result  in  WIDTH  combinational ALU result (PC+4)
alu_out  in  WIDTH  registered ALU output (branch target)
jump_address  in  WIDTH  fully formed jump target, used verbatim
exc_req  in  1  exception request from control
pc_out  out  WIDTH  current PC
pc_prev  out  WIDTH  PC before the last fetch increment
epc  out  WIDTH  PC at the last exception
exc_taken  out  1  one-cycle pulse, the cycle after a redirect
misalign  out  1  one-cycle pulse on misaligned target (feature only)
update_count  out  CNT_WIDTH  number of PC updates since reset, wraps

Behaviour:
- Reset: all of the following take effect on the next clk edge with reset=1, overriding everything.
  - pc_out=RESET_VEC, pc_prev=RESET_VEC.
  - epc=0, exc_taken=0, misalign=0, update_count=0.
  - state=RUN, hold counter=0.
- take = pc_write | (pc_write_cond & (zero ^ branch_ne)).
- target = mux(pc_src); pc_src=3 selects EXC_VEC.
- FSM states: RUN, HOLD.
- RUN, priority is exc_req > take:
  - exc_req=1: pc_out<=EXC_VEC; epc<=pc_out; exc_taken<=1; update_count+1. Go to HOLD if HOLD_CYCLES>0, else stay in RUN.
  - take=1 (no exc_req): pc_out<=target; update_count+1. If pc_src==0, pc_prev<=pc_out.
  - Neither: hold all registers.
- HOLD:
  - take and exc_req are ignored; the PC is frozen.
  - Counter loads HOLD_CYCLES on entry and decrements each cycle; return to RUN on the cycle it reaches 1.
- exc_taken and misalign are high for exactly one cycle, otherwise 0.
- Latency: one clock from a take/exc_req sample to the new pc_out; no combinational path from inputs to pc_out.
- update_count wraps from all-ones to 0 silently.
- Simultaneous pc_write and pc_write_cond: take is their OR; the target is still chosen by pc_src.
- Reset asserted during HOLD: returns to RUN with the reset values above.

Optional Feature:
PC_MISALIGN_TRAP_EN.
- Defined:
  - In RUN, a take whose target[ALIGN_BITS-1:0]!=0 is treated as an exception.
  - pc_out<=EXC_VEC; epc<=pc_out; exc_taken<=1; misalign<=1; enter HOLD as for exc_req.
  - An explicit exc_req in the same cycle gives the same result, with misalign=1.
- Undefined:
  - The target is loaded verbatim; misalign is tied to 0.

Decomposition:
- Shared package (cpu_pkg):
  - PC_SRC_ALU=2'd0, PC_SRC_ALUOUT=2'd1, PC_SRC_JUMP=2'd2, PC_SRC_EXC=2'd3.
  - Default WIDTH and EXC_VEC constants.
  - Typedef for the RUN/HOLD state enum.
- One sub-module, pc_next_sel: the combinational take-qualification and 4-way target mux (plus misalign detect). Registers, FSM and counters stay in the top.

Test Plan:
- Reset, then pc_write=1, pc_src=0, alu_result stepping +4 for 5 edges -> pc_out 0,4,8,12,16,20; pc_prev trails by one step; update_count=5.
- pc_write_cond=1, branch_ne=0, alu_out='h40 -> taken at zero=1 (pc_out='h40), not taken at zero=0. With branch_ne=1 the outcome inverts.
- pc_src=2, jump_address='h1000, pc_write=1 -> pc_out='h1000 next cycle; pc_prev unchanged.
- At pc_out='h1000, exc_req=1 together with pc_write=1 -> pc_out='h180, epc='h1000, exc_taken pulses once. With HOLD_CYCLES=1, a pc_write the next cycle is ignored; the one after updates the PC.
- With PC_MISALIGN_TRAP_EN, jump to 'h1002 -> pc_out='h180, misalign=1 for one cycle. Without the macro -> pc_out='h1002, misalign=0.
- Reset asserted during HOLD, and CNT_WIDTH=4 after 16 updates -> PC=RESET_VEC, state RUN, and update_count wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: PC source encodings,
// default PC width / exception vector, PC-unit FSM state type and the
// branch-qualification helper.
package cpu_pkg;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_EXC    = 2'd3;

    localparam int          PC_WIDTH_DEF = 32;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_0180;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_e;

    // Unconditional write, or a conditional write whose beq/bne test passes.
    function automatic logic branch_take(input logic pc_write,
                                         input logic pc_write_cond,
                                         input logic zero,
                                         input logic branch_ne);
        return pc_write | (pc_write_cond & (zero ^ branch_ne));
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: write qualification, 4-way target mux and
// detection of targets whose low ALIGN_BITS are not zero.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int               WIDTH      = PC_WIDTH_DEF,
    parameter int               ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(EXC_VEC_DEF)
) (
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic             zero,
    input  logic             branch_ne,
    input  logic [1:0]       pc_src,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] jump_address,
    output logic             take,
    output logic [WIDTH-1:0] target,
    output logic             misaligned
);

    // Mask of the address bits that must be zero for a legal target.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    assign take = branch_take(pc_write, pc_write_cond, zero, branch_ne);

    // Select the candidate next PC from the datapath sources.
    always_comb begin
        target = alu_result;
        case (pc_src)
            PC_SRC_ALU:    target = alu_result;
            PC_SRC_ALUOUT: target = alu_out;
            PC_SRC_JUMP:   target = jump_address;
            PC_SRC_EXC:    target = EXC_VEC;
            default:       target = EXC_VEC;
        endcase
    end

    assign misaligned = |(target & ALIGN_MASK);

endmodule

// File: rtl/pc_unit_param.sv
// Parametrised program-counter unit: PC register, exception redirect with EPC
// capture, post-trap hold window and a wrapping PC-update counter.
// Optional feature: define PC_MISALIGN_TRAP_EN to turn a taken write to a
// misaligned target into an exception (with a one-cycle misalign pulse).
module pc_unit_param
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0,
    parameter logic [WIDTH-1:0] EXC_VEC     = WIDTH'(EXC_VEC_DEF),
    parameter int               ALIGN_BITS  = 2,
    parameter int               HOLD_CYCLES = 1,
    parameter int               CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_write,
    input  logic                 pc_write_cond,
    input  logic                 zero,
    input  logic                 branch_ne,
    input  logic [1:0]           pc_src,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic [WIDTH-1:0]     jump_address,
    input  logic                 exc_req,
    output logic [WIDTH-1:0]     pc_out,
    output logic [WIDTH-1:0]     pc_prev,
    output logic [WIDTH-1:0]     epc,
    output logic                 exc_taken,
    output logic                 misalign,
    output logic [CNT_WIDTH-1:0] update_count
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    pc_state_e             state_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [WIDTH-1:0]      pc_q;
    logic [WIDTH-1:0]      pc_prev_q;
    logic [WIDTH-1:0]      epc_q;
    logic                  exc_taken_q;
    logic                  misalign_q;
    logic [CNT_WIDTH-1:0]  update_count_q;
    logic [CNT_WIDTH-1:0]  update_count_d;

    logic                  take_s;
    logic [WIDTH-1:0]      target_s;
    logic                  misaligned_s;
    logic                  trap_s;
    logic                  redirect_s;

    pc_next_sel #(
        .WIDTH      (WIDTH),
        .ALIGN_BITS (ALIGN_BITS),
        .EXC_VEC    (EXC_VEC)
    ) u_next_sel (
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .branch_ne     (branch_ne),
        .pc_src        (pc_src),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .jump_address  (jump_address),
        .take          (take_s),
        .target        (target_s),
        .misaligned    (misaligned_s)
    );

    // A misaligned taken write only traps when the feature is built in.
    assign trap_s         = TRAP_EN & take_s & misaligned_s;
    assign redirect_s     = exc_req | trap_s;
    assign update_count_d = update_count_q + CNT_WIDTH'(1);

    // RUN/HOLD FSM owning the PC, EPC, pulse outputs and update counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            hold_q         <= '0;
            pc_q           <= RESET_VEC;
            pc_prev_q      <= RESET_VEC;
            epc_q          <= '0;
            exc_taken_q    <= 1'b0;
            misalign_q     <= 1'b0;
            update_count_q <= '0;
        end else begin
            exc_taken_q <= 1'b0;
            misalign_q  <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (redirect_s) begin
                        pc_q           <= EXC_VEC;
                        epc_q          <= pc_q;
                        exc_taken_q    <= 1'b1;
                        misalign_q     <= trap_s;
                        update_count_q <= update_count_d;
                        if (HOLD_CYCLES > 0) begin
                            state_q <= ST_HOLD;
                            hold_q  <= HOLD_LOAD;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else if (take_s) begin
                        pc_q           <= target_s;
                        update_count_q <= update_count_d;
                        // Only the sequential fetch increment records the old PC.
                        if (pc_src == PC_SRC_ALU) begin
                            pc_prev_q <= pc_q;
                        end else begin
                            pc_prev_q <= pc_prev_q;
                        end
                    end else begin
                        pc_q <= pc_q;
                    end
                end
                ST_HOLD: begin
                    // PC frozen; leave on the cycle the counter reaches 1.
                    if (hold_q <= HOLD_W'(1)) begin
                        state_q <= ST_RUN;
                        hold_q  <= '0;
                    end else begin
                        hold_q  <= hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign pc_out       = pc_q;
    assign pc_prev      = pc_prev_q;
    assign epc          = epc_q;
    assign exc_taken    = exc_taken_q;
    assign misalign     = misalign_q;
    assign update_count = update_count_q;

endmodule

// File: tb/tb_pc_unit_param.sv
// Scoreboard bench for pc_unit_param (WIDTH=32, HOLD_CYCLES=1, CNT_WIDTH=4).
// The stimulus process drives one cycle of inputs at the falling edge and
// queues the hand-computed register state expected after the next rising
// edge; an independent monitor pops and compares shortly after that edge.
module tb_pc_unit_param;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic        pc_write_cond;
    logic        zero;
    logic        branch_ne;
    logic [1:0]  pc_src;
    logic [31:0] alu_result;
    logic [31:0] alu_out;
    logic [31:0] jump_address;
    logic        exc_req;
    logic [31:0] pc_out;
    logic [31:0] pc_prev;
    logic [31:0] epc;
    logic        exc_taken;
    logic        misalign;
    logic [3:0]  update_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] prev;
        logic [31:0] epc;
        logic        exc;
        logic        mis;
        logic [3:0]  cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    pc_unit_param #(
        .WIDTH       (32),
        .RESET_VEC   (32'h0),
        .EXC_VEC     (32'h180),
        .ALIGN_BITS  (2),
        .HOLD_CYCLES (1),
        .CNT_WIDTH   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .branch_ne     (branch_ne),
        .pc_src        (pc_src),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .jump_address  (jump_address),
        .exc_req       (exc_req),
        .pc_out        (pc_out),
        .pc_prev       (pc_prev),
        .epc           (epc),
        .exc_taken     (exc_taken),
        .misalign      (misalign),
        .update_count  (update_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, expv);
        end
    endtask

    // Monitor: the DUT presents a new registered state after every rising edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, "pc_out",       pc_out,              e.pc);
                check(nm, "pc_prev",      pc_prev,             e.prev);
                check(nm, "epc",          epc,                 e.epc);
                check(nm, "exc_taken",    {31'd0, exc_taken},  {31'd0, e.exc});
                check(nm, "misalign",     {31'd0, misalign},   {31'd0, e.mis});
                check(nm, "update_count", {28'd0, update_count}, {28'd0, e.cnt});
            end
        end
    end

    task automatic drive(input logic rst, input logic pcw, input logic cond,
                         input logic z, input logic bne, input logic [1:0] src,
                         input logic [31:0] ares, input logic [31:0] aout,
                         input logic [31:0] jmp, input logic exc);
        reset         = rst;
        pc_write      = pcw;
        pc_write_cond = cond;
        zero          = z;
        branch_ne     = bne;
        pc_src        = src;
        alu_result    = ares;
        alu_out       = aout;
        jump_address  = jmp;
        exc_req       = exc;
    endtask

    // Queue the expectation for the edge that follows, then move to the next falling edge.
    task automatic step(input string nm, input logic [31:0] pc, input logic [31:0] prev,
                        input logic [31:0] ep, input logic ex, input logic mi,
                        input logic [3:0] cnt);
        exp_t e;
        e.pc   = pc;
        e.prev = prev;
        e.epc  = ep;
        e.exc  = ex;
        e.mis  = mi;
        e.cnt  = cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        step("reset0", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
        step("reset1", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);

        // Sequential fetch: pc_prev trails pc_out by one increment.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'(4 * i), 32'h0, 32'h0, 1'b0);
            step("inc", 32'(4 * i), 32'(4 * (i - 1)), 32'h0, 1'b0, 1'b0, 4'(i));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h99, 32'h0, 32'h0, 1'b0);
        step("idle", 32'd20, 32'd16, 32'h0, 1'b0, 1'b0, 4'd5);

        // beq / bne qualification.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0, 32'h40, 32'h0, 1'b0);
        step("beq_nt", 32'd20, 32'd16, 32'h0, 1'b0, 1'b0, 4'd5);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0, 32'h40, 32'h0, 1'b0);
        step("beq_t", 32'h40, 32'd16, 32'h0, 1'b0, 1'b0, 4'd6);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0, 32'h80, 32'h0, 1'b0);
        step("bne_nt", 32'h40, 32'd16, 32'h0, 1'b0, 1'b0, 4'd6);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0, 32'h80, 32'h0, 1'b0);
        step("bne_t", 32'h80, 32'd16, 32'h0, 1'b0, 1'b0, 4'd7);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0, 32'hC0, 32'h0, 1'b0);
        step("both_wr", 32'hC0, 32'd16, 32'h0, 1'b0, 1'b0, 4'd8);

        // Jump, then exception together with a write.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h1000, 1'b0);
        step("jump", 32'h1000, 32'd16, 32'h0, 1'b0, 1'b0, 4'd9);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1004, 32'h0, 32'h0, 1'b1);
        step("exc", 32'h180, 32'd16, 32'h1000, 1'b1, 1'b0, 4'd10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h184, 32'h0, 32'h0, 1'b0);
        step("hold_ign", 32'h180, 32'd16, 32'h1000, 1'b0, 1'b0, 4'd10);
        step("post_hold", 32'h184, 32'h180, 32'h1000, 1'b0, 1'b0, 4'd11);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 32'h0, 1'b0);
        step("src_exc", 32'h180, 32'h180, 32'h1000, 1'b0, 1'b0, 4'd12);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h200, 32'h0, 32'h0, 1'b0);
        step("inc200", 32'h200, 32'h180, 32'h1000, 1'b0, 1'b0, 4'd13);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        step("exc2", 32'h180, 32'h180, 32'h200, 1'b1, 1'b0, 4'd14);
        step("exc_in_hold", 32'h180, 32'h180, 32'h200, 1'b0, 1'b0, 4'd14);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        step("idle2", 32'h180, 32'h180, 32'h200, 1'b0, 1'b0, 4'd14);

        // Misaligned jump target.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h1002, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        step("misal", 32'h180, 32'h180, 32'h180, 1'b1, 1'b1, 4'd15);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        step("misal_end", 32'h180, 32'h180, 32'h180, 1'b0, 1'b0, 4'd15);
`else
        step("misal", 32'h1002, 32'h180, 32'h200, 1'b0, 1'b0, 4'd15);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        step("misal_end", 32'h1002, 32'h180, 32'h200, 1'b0, 1'b0, 4'd15);
`endif

        // Counter wraps from 15 to 0.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h2000, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        step("wrap", 32'h2000, 32'h180, 32'h180, 1'b0, 1'b0, 4'd0);
`else
        step("wrap", 32'h2000, 32'h180, 32'h200, 1'b0, 1'b0, 4'd0);
`endif

        // Reset in the middle of the hold window.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        step("exc3", 32'h180, 32'h180, 32'h2000, 1'b1, 1'b0, 4'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h300, 32'h0, 32'h0, 1'b1);
        step("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h4, 32'h0, 32'h0, 1'b0);
        step("run_after_rst", 32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 4'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Bounded drain of the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
